prog_uart_loader: RTL and testbench

//  Boot-time program loader between the board program_rx pin and main memory. A UART receiver

---
 rtl/prog_uart_loader.sv | 214 +++++++++++++++++++++
 tb/tb_prog_uart_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_uart_loader.sv
// Boot loader: UART magic-word hunt, length-prefixed image streamed to memory.
// Optional PROG_CHECKSUM_EN adds a trailing wrapping-sum word check (state CSUM).
module prog_uart_loader #(
    parameter int unsigned BAUD_DIV    = 868,
    parameter logic [31:0] PROG_MAGIC  = 32'h50524F47,
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter logic [31:0] MAX_WORDS   = 32'd32768,
    parameter logic [31:0] TIMEOUT_CYC = 32'd10_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        prog_rx_i,
    output logic        prog_mode_o,
    output logic        core_rst_no,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        load_err_o
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_DONE, S_CSUM
    } state_t;

`ifdef PROG_CHECKSUM_EN
    localparam state_t AFTER_DATA = S_CSUM;
`else
    localparam state_t AFTER_DATA = S_DONE;
`endif

    logic          r_rx_s1, r_rx_s2, r_rx_d;
    logic          r_busy;
    logic [BW-1:0] r_baud;
    logic [3:0]    r_bit;
    logic [7:0]    r_rx_sh;
    logic          r_stb, r_ferr;

    state_t        r_state, w_next;
    logic [31:0]   r_sr;
    logic [1:0]    r_bcnt;
    logic [31:0]   r_to;
    logic [31:0]   r_rem;
    logic          r_mem_valid;
    logic [31:0]   r_mem_addr, r_mem_wdata;
    logic          r_err, r_hold, r_run;

    logic          w_fall, w_word_done, w_magic, w_hs;
    logic          w_active, w_timeout, w_len_ok, w_overrun;
    logic          w_csum_bad;
    logic [31:0]   w_sr_nxt;

    assign w_fall      = r_rx_d & ~r_rx_s2;
    assign w_sr_nxt    = {r_rx_sh, r_sr[31:8]};
    assign w_word_done = r_stb & (r_bcnt == 2'd3);
    assign w_magic     = r_stb & (r_state == S_IDLE) & (w_sr_nxt == PROG_MAGIC);
    assign w_hs        = r_mem_valid & mem_ready_i;
    assign w_active    = (r_state == S_LEN) | (r_state == S_DATA) | (r_state == S_CSUM);
    assign w_timeout   = w_active & ~r_stb & ~r_mem_valid
                       & (r_to == TIMEOUT_CYC - 32'd1);
    assign w_len_ok    = (w_sr_nxt != 32'd0) & (w_sr_nxt <= MAX_WORDS);
    assign w_overrun   = (r_state == S_DATA) & w_word_done & r_mem_valid;

`ifdef PROG_CHECKSUM_EN
    logic [31:0] r_csum;
    assign w_csum_bad = (r_state == S_CSUM) & w_word_done & (w_sr_nxt != r_csum);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_csum <= 32'd0;
        end else if (r_state == S_LEN) begin
            r_csum <= 32'd0;
        end else if (r_state == S_DATA && w_word_done && !r_mem_valid) begin
            r_csum <= r_csum + w_sr_nxt;
        end
    end
`else
    assign w_csum_bad = 1'b0;
`endif

    // 2-FF synchronizer, then a mid-bit sampling 8N1 receiver
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_d  <= 1'b1;
            r_busy  <= 1'b0;
            r_baud  <= '0;
            r_bit   <= 4'd0;
            r_rx_sh <= 8'd0;
            r_stb   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_rx_s1 <= prog_rx_i;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
            r_stb   <= 1'b0;
            r_ferr  <= 1'b0;
            if (!r_busy) begin
                if (w_fall) begin
                    r_busy <= 1'b1;
                    r_baud <= '0;
                    r_bit  <= 4'd0;
                end
            end else begin
                if (r_baud == BAUD_LAST) begin
                    r_baud <= '0;
                    r_bit  <= r_bit + 4'd1;
                end else begin
                    r_baud <= r_baud + 1'b1;
                end
                if (r_baud == BAUD_HALF) begin
                    if (r_bit == 4'd0) begin
                        if (r_rx_s2) r_busy <= 1'b0;
                    end else if (r_bit == 4'd9) begin
                        r_busy <= 1'b0;
                        r_stb  <= r_rx_s2;
                        r_ferr <= ~r_rx_s2;
                    end else begin
                        r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_magic) w_next = S_LEN;
            S_LEN: begin
                if (w_timeout) w_next = S_IDLE;
                else if (w_word_done) begin
                    if (w_sr_nxt == 32'd0)       w_next = AFTER_DATA;
                    else if (w_sr_nxt > MAX_WORDS) w_next = S_IDLE;
                    else                          w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_timeout) w_next = S_IDLE;
                else if (w_hs && r_rem == 32'd1) w_next = AFTER_DATA;
            end
            S_CSUM: begin
                if (w_timeout) w_next = S_IDLE;
                else if (w_word_done) w_next = w_csum_bad ? S_IDLE : S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        prog_mode_o = w_active | r_hold;
        core_rst_no = r_run & ~(w_active | r_hold);
        mem_valid_o = r_mem_valid;
        mem_addr_o  = r_mem_addr;
        mem_wdata_o = r_mem_wdata;
        load_err_o  = r_err;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sr        <= 32'd0;
            r_bcnt      <= 2'd0;
            r_to        <= 32'd0;
            r_rem       <= 32'd0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_err       <= 1'b0;
            r_hold      <= 1'b0;
            r_run       <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_stb) r_sr <= w_sr_nxt;
            if (w_next != r_state) r_bcnt <= 2'd0;
            else if (r_stb)        r_bcnt <= r_bcnt + 2'd1;
            if (!w_active || r_stb || r_mem_valid || w_next != r_state)
                r_to <= 32'd0;
            else
                r_to <= r_to + 32'd1;
            if (r_state == S_LEN && w_word_done && w_len_ok) begin
                r_mem_addr <= BASE_ADDR;
                r_rem      <= w_sr_nxt;
            end
            if (w_hs) begin
                r_mem_valid <= 1'b0;
                r_mem_addr  <= r_mem_addr + 32'd4;
                r_rem       <= r_rem - 32'd1;
            end
            if (r_state == S_DATA && w_word_done && !r_mem_valid) begin
                r_mem_valid <= 1'b1;
                r_mem_wdata <= w_sr_nxt;
            end
            if (w_magic) begin
                r_err  <= 1'b0;
                r_hold <= 1'b0;
            end else begin
                if ((r_ferr && r_state != S_IDLE) || w_overrun || w_timeout
                    || w_csum_bad
                    || (r_state == S_LEN && w_word_done && w_sr_nxt > MAX_WORDS))
                    r_err <= 1'b1;
                if (w_csum_bad) r_hold <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_prog_uart_loader.sv
// Directed bench for prog_uart_loader with a fast baud rate and short timeout.
// Builds with or without PROG_CHECKSUM_EN.
module tb_prog_uart_loader;
    localparam int BAUD = 16;
    localparam int TOUT = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        ready = 1'b0;
    logic        prog_mode, core_rst_n, mem_valid, load_err;
    logic [31:0] mem_addr, mem_wdata;

    int checks = 0;
    int errors = 0;
    int wr_n = 0;
    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];

    prog_uart_loader #(
        .BAUD_DIV(BAUD),
        .TIMEOUT_CYC(32'(TOUT))
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .prog_rx_i(rx),
        .prog_mode_o(prog_mode),
        .core_rst_no(core_rst_n),
        .mem_valid_o(mem_valid),
        .mem_ready_i(ready),
        .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata),
        .load_err_o(load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && mem_valid && ready && wr_n < 64) begin
            wr_addr[wr_n] = mem_addr;
            wr_data[wr_n] = mem_wdata;
            wr_n++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx = 1'b0;
        cycles(BAUD);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(BAUD);
        end
        rx = 1'b1;
        cycles(BAUD);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_csum(input logic [31:0] s);
`ifdef PROG_CHECKSUM_EN
        send_word(s);
`else
        if (s == 32'hFFFF_FFFF) cycles(1);
`endif
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cycles(3);
        checks++;
        if (core_rst_n !== 1'b0 || mem_valid !== 1'b0 || prog_mode !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold core=%b valid=%b mode=%b want 0 0 0",
                     core_rst_n, mem_valid, prog_mode);
        end
        rst_n = 1'b1;
        cycles(2);
        checks++;
        if (core_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_core_rel got %b want 1", core_rst_n);
        end
        checks++;
        if (prog_mode !== 1'b0 || mem_valid !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle mode=%b valid=%b err=%b want 0 0 0",
                     prog_mode, mem_valid, load_err);
        end
    endtask

    task automatic test_load;
        int b;
        b = wr_n;
        ready = 1'b1;
        send_word(32'h50524F47);
        cycles(2);
        checks++;
        if (prog_mode !== 1'b1 || core_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL load_magic mode=%b core=%b want 1 0", prog_mode, core_rst_n);
        end
        send_word(32'd2);
        send_word(32'h11223344);
        checks++;
        if (core_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL load_mid_core got %b want 0", core_rst_n);
        end
        send_word(32'hAABBCCDD);
        send_csum(32'hBBDE0021);
        cycles(4);
        checks++;
        if (wr_n - b !== 2) begin
            errors++;
            $display("FAIL load_count got %0d want 2", wr_n - b);
        end else begin
            checks++;
            if (wr_addr[b] !== 32'h4000_0000 || wr_data[b] !== 32'h11223344) begin
                errors++;
                $display("FAIL load_w0 got %h=%h want 40000000=11223344",
                         wr_addr[b], wr_data[b]);
            end
            checks++;
            if (wr_addr[b+1] !== 32'h4000_0004 || wr_data[b+1] !== 32'hAABBCCDD) begin
                errors++;
                $display("FAIL load_w1 got %h=%h want 40000004=aabbccdd",
                         wr_addr[b+1], wr_data[b+1]);
            end
        end
        checks++;
        if (core_rst_n !== 1'b1 || prog_mode !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL load_done core=%b mode=%b err=%b want 1 0 0",
                     core_rst_n, prog_mode, load_err);
        end
    endtask

    task automatic test_overrun;
        int b;
        b = wr_n;
        ready = 1'b0;
        send_word(32'h50524F47);
        send_word(32'd2);
        send_word(32'h11223344);
        cycles(2);
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h4000_0000 || mem_wdata !== 32'h11223344) begin
            errors++;
            $display("FAIL ovr_pending valid=%b %h=%h want 1 40000000=11223344",
                     mem_valid, mem_addr, mem_wdata);
        end
        send_word(32'hAABBCCDD);
        cycles(2);
        checks++;
        if (load_err !== 1'b1 || mem_wdata !== 32'h11223344 || wr_n !== b) begin
            errors++;
            $display("FAIL ovr_flag err=%b data=%h writes=%0d want 1 11223344 0",
                     load_err, mem_wdata, wr_n - b);
        end
        ready = 1'b1;
        cycles(3);
        checks++;
        if (wr_n - b !== 1 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_once writes=%0d valid=%b want 1 0", wr_n - b, mem_valid);
        end
        send_word(32'h55667788);
        send_csum(32'h6688AACC);
        cycles(4);
        checks++;
        if (wr_n - b !== 2) begin
            errors++;
            $display("FAIL ovr_count got %0d want 2", wr_n - b);
        end else begin
            checks++;
            if (wr_addr[b+1] !== 32'h4000_0004 || wr_data[b+1] !== 32'h55667788) begin
                errors++;
                $display("FAIL ovr_w1 got %h=%h want 40000004=55667788",
                         wr_addr[b+1], wr_data[b+1]);
            end
        end
        checks++;
        if (core_rst_n !== 1'b1 || load_err !== 1'b1) begin
            errors++;
            $display("FAIL ovr_done core=%b err=%b want 1 1", core_rst_n, load_err);
        end
    endtask

    task automatic test_len_reject;
        int b;
        b = wr_n;
        ready = 1'b1;
        send_word(32'h50524F47);
        cycles(2);
        checks++;
        if (load_err !== 1'b0) begin
            errors++;
            $display("FAIL rej_clear got %b want 0", load_err);
        end
        send_word(32'h0001_0000);
        cycles(4);
        checks++;
        if (wr_n !== b || load_err !== 1'b1 || core_rst_n !== 1'b1 || prog_mode !== 1'b0) begin
            errors++;
            $display("FAIL rej_len writes=%0d err=%b core=%b mode=%b want 0 1 1 0",
                     wr_n - b, load_err, core_rst_n, prog_mode);
        end
    endtask

    task automatic test_timeout;
        int b;
        b = wr_n;
        ready = 1'b1;
        send_word(32'h50524F47);
        send_word(32'd4);
        send_word(32'hDEADBEEF);
        cycles(4);
        checks++;
        if (prog_mode !== 1'b1 || load_err !== 1'b0 || wr_n - b !== 1) begin
            errors++;
            $display("FAIL to_before mode=%b err=%b writes=%0d want 1 0 1",
                     prog_mode, load_err, wr_n - b);
        end
        cycles(TOUT + 10);
        checks++;
        if (load_err !== 1'b1 || core_rst_n !== 1'b1 || prog_mode !== 1'b0) begin
            errors++;
            $display("FAIL to_abort err=%b core=%b mode=%b want 1 1 0",
                     load_err, core_rst_n, prog_mode);
        end
        checks++;
        if (wr_n - b !== 1 || wr_data[b] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL to_write writes=%0d data=%h want 1 deadbeef",
                     wr_n - b, wr_data[b]);
        end
    endtask

    task automatic test_reset_abort;
        ready = 1'b0;
        send_word(32'h50524F47);
        send_word(32'd1);
        send_word(32'hCAFEF00D);
        cycles(2);
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_valid !== 1'b0 || core_rst_n !== 1'b0 || prog_mode !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort valid=%b core=%b mode=%b want 0 0 0",
                     mem_valid, core_rst_n, prog_mode);
        end
        cycles(2);
        rst_n = 1'b1;
        ready = 1'b1;
        cycles(2);
    endtask

`ifdef PROG_CHECKSUM_EN
    task automatic test_checksum;
        ready = 1'b1;
        send_word(32'h50524F47);
        send_word(32'd1);
        send_word(32'h5);
        send_word(32'h6);
        cycles(4);
        checks++;
        if (load_err !== 1'b1 || core_rst_n !== 1'b0 || prog_mode !== 1'b1) begin
            errors++;
            $display("FAIL csum_bad err=%b core=%b mode=%b want 1 0 1",
                     load_err, core_rst_n, prog_mode);
        end
        send_word(32'h50524F47);
        send_word(32'd1);
        send_word(32'h5);
        send_word(32'h5);
        cycles(4);
        checks++;
        if (load_err !== 1'b0 || core_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL csum_ok err=%b core=%b want 0 1", load_err, core_rst_n);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_load;
        test_overrun;
        test_len_reject;
        test_timeout;
        test_reset_abort;
`ifdef PROG_CHECKSUM_EN
        test_checksum;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
